// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: request bundle, read encoding, port ids.
package data_mem_arb_pkg;

  typedef struct packed {
    logic [3:0]  we;
    logic [11:2] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [3:0] WE_READ = 4'b0000;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

endpackage

// File: rtl/data_memory_arbiter_starve_counter.sv
// Saturating wait counter for the low-priority port; o_at_limit forces its grant.
module starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt >= LIMIT);

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter for a synchronous-read data memory: CPU has priority, debug port
// gets a forced grant after a bounded wait; read responses return to the issuing port.
module data_memory_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_valid,
  output logic        o_p0_ready,
  input  logic [3:0]  i_p0_we,
  input  logic [9:0]  i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_valid,
  output logic        o_p1_ready,
  input  logic [3:0]  i_p1_we,
  input  logic [9:0]  i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  output logic [3:0]  o_mem_we,
  output logic [9:0]  o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  logic     w_at_limit;
  logic     w_gnt0;
  logic     w_gnt1;
  logic     w_rd_gnt;
  mem_req_t w_req0;
  mem_req_t w_req1;
  mem_req_t w_req;
  logic     r_rd_pend;
  port_id_t r_rd_port;

  assign w_req0 = '{we: i_p0_we, addr: i_p0_addr, wdata: i_p0_wdata};
  assign w_req1 = '{we: i_p1_we, addr: i_p1_addr, wdata: i_p1_wdata};

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_p1_valid && w_at_limit) begin
        w_gnt1 = 1'b1;
      end else if (i_p0_valid) begin
        w_gnt0 = 1'b1;
      end else if (i_p1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  // Idle cycles drive zeros so the memory never sees a stale write enable.
  always_comb begin
    w_req = '0;
    if (w_gnt0) begin
      w_req = w_req0;
    end else if (w_gnt1) begin
      w_req = w_req1;
    end
  end

  assign w_rd_gnt = (w_gnt0 || w_gnt1) && (w_req.we == WE_READ);

  assign o_p0_ready  = w_gnt0;
  assign o_p1_ready  = w_gnt1;
  assign o_mem_we    = w_req.we;
  assign o_mem_addr  = w_req.addr;
  assign o_mem_wdata = w_req.wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pend <= 1'b0;
      r_rd_port <= PORT_CPU;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_port <= w_gnt1 ? PORT_DBG : PORT_CPU;
      end
    end
  end

  // Masking with reset drops a response whose read was granted just before reset.
  assign o_p0_rvalid = r_rd_pend && !i_rst && (r_rd_port == PORT_CPU);
  assign o_p1_rvalid = r_rd_pend && !i_rst && (r_rd_port == PORT_DBG);
  assign o_p0_rdata  = i_mem_rdata;
  assign o_p1_rdata  = i_mem_rdata;

  starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_gnt1 || !i_p1_valid),
    .i_inc      (i_p1_valid && w_gnt0),
    .o_at_limit (w_at_limit)
  );

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (CPU MEM stage) and port 1 (debug/DMA loader).
- Port 0 has fixed priority, with a starvation guard that forces a port 1 grant after a bounded wait.
- The memory side is synchronous-read: rdata is valid one cycle after the address is presented.
- The block routes each read response back to the port that issued it.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port 1 may be refused while valid before it gets forced priority; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_valid  in  1  port 0 request valid.
- p0_ready  out  1  port 0 request accepted this cycle.
- p0_we  in  4  port 0 byte write enables; 0000 = read.
- p0_addr  in  10  port 0 word address [11:2].
- p0_wdata  in  32  port 0 store data.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  32  port 0 read data.
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_we  out  4  byte write enables to memory.
- mem_addr  out  10  word address to memory [11:2].
- mem_wdata  out  32  store data to memory.
- mem_rdata  in  32  read data from memory; valid one cycle after address.

Behaviour:
- Arbitration is combinational from inputs plus registered state; at most one grant per cycle. Grant means pX_ready=1, and a transfer occurs when valid&&ready.
- Grant rule:
  - If p1_valid && starve_cnt >= STARVE_LIMIT, grant port 1.
  - Otherwise, if p0_valid, grant port 0.
  - Otherwise, if p1_valid, grant port 1.
  - Otherwise, no grant.
- pX_ready is never asserted when pX_valid=0.
- Memory outputs:
  - On a grant, mem_we/mem_addr/mem_wdata = the granted port's we/addr/wdata.
  - With no grant, mem_we=0000, mem_addr=0, mem_wdata=0.
- Starvation counter:
  - Clears to 0 when port 1 is granted or when p1_valid=0.
  - Increments, saturating at STARVE_LIMIT, when p1_valid=1 and port 0 is granted.
- Read tracking:
  - Registers rd_pend (1 bit) and rd_port (1 bit), set when a granted request has we==0000; rd_pend clears the following cycle unless another read is granted.
- Response:
  - In the cycle after a granted read, pX_rvalid=1 for X=rd_pend_port, and pX_rdata=mem_rdata.
  - The other port's rvalid=0. rdata outputs = mem_rdata at all times; only rvalid qualifies them.
- Throughput and latency:
  - A read costs 1 cycle of arbitration with 1-cycle latency; back-to-back reads from either port are allowed every cycle.
  - A write completes in the grant cycle and produces no rvalid.
  - Responses cannot be back-pressured; requesters must accept rvalid.
- Latched inputs: a requester must hold valid/we/addr/wdata stable until ready; the arbiter does not latch them.
- Reset:
  - Values: rd_pend=0, rd_port=0, starve_cnt=0, all rvalid=0.
  - Reset asserted the cycle after a read grant drops that response (no rvalid).
  - Grants are suppressed while rst=1 (all ready=0, mem_we=0000).
- Boundary: both valid with starve_cnt == STARVE_LIMIT-1 → port 0 wins, counter reaches STARVE_LIMIT, port 1 wins next cycle.

Decomposition:
- Package data_mem_arb_pkg:
  - typedef mem_req_t {we[3:0], addr[11:2], wdata[31:0]}
  - constant WE_READ = 4'b0000
  - enum port_id_t {PORT_CPU=0, PORT_DBG=1}
- One natural sub-module, starve_counter: a saturating counter with clear/inc inputs and an at_limit output. Arbitration and response routing stay in the top module.

Test Plan:
- Port 0 read addr 0x010, memory word 0xDEADBEEF → p0_ready same cycle, mem_we=0000, mem_addr=0x010; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p1_rvalid=0.
- Port 1 write we=0011 addr 0x3FF wdata 0x12345678, port 0 idle → p1_ready=1, mem_we=0011, mem_addr=0x3FF, mem_wdata=0x12345678; no rvalid the next cycle.
- Both ports valid continuously with STARVE_LIMIT=4 → grants P0,P0,P0,P0,P1, repeating; starve_cnt observed 0,1,2,3,4,0.
- Interleaved reads P0 (addr 0x001), P1 (addr 0x002) on consecutive cycles → rvalid on port 0 in cycle 2 with word@0x001, on port 1 in cycle 3 with word@0x002; never both rvalid in one cycle.
- Read granted, then rst=1 the next cycle → no rvalid on either port; after rst deasserts, all outputs are at reset values and a new port 0 read completes normally.
- Idle, no valids → mem_we=0000, mem_addr=0, all ready=0, starve_cnt stays 0.
